// File: rtl/spi_keycode_slave_pkg.sv
// rager_spi_pkg: shared types and constants for the SPI keycode slave.
//   state_t   - transaction FSM states
//   wr_req_t  - committed-write record (strobe/addr/data) driven to the top outputs
//   ADDR_*    - register map; address 0 is the read-only status byte
//   CMD_*     - MAX3421E-style command byte fields: cmd[7:3]=addr, cmd[1]=dir (1=write)
package rager_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [4:0] ADDR_STATUS = 5'd0;
  localparam logic [4:0] ADDR_KEY0   = 5'd1;
  localparam logic [4:0] ADDR_KEY1   = 5'd2;
  localparam logic [4:0] ADDR_KEY2   = 5'd3;
  localparam logic [4:0] ADDR_SHOOT  = 5'd4;

  localparam int CMD_DIR_BIT  = 1;
  localparam int CMD_ADDR_MSB = 7;
  localparam int CMD_ADDR_LSB = 3;

  typedef struct packed {
    logic       strobe;
    logic [4:0] addr;
    logic [7:0] data;
  } wr_req_t;

endpackage

// File: rtl/spi_keycode_slave_if.sv
// spi_keycode_slave_if: SPI pin bundle between an external master and the slave.
//   spi_sclk/spi_ss_n/spi_mosi : master -> slave (asynchronous to Clk)
//   spi_miso/spi_miso_oe       : slave -> master (oe gates the external tri-state)
interface spi_keycode_slave_if;
  logic spi_sclk;
  logic spi_ss_n;
  logic spi_mosi;
  logic spi_miso;
  logic spi_miso_oe;

  modport slave  (input  spi_sclk, spi_ss_n, spi_mosi, output spi_miso, spi_miso_oe);
  modport master (output spi_sclk, spi_ss_n, spi_mosi, input  spi_miso, spi_miso_oe);
endinterface

// File: rtl/spi_keycode_slave_sync_edge.sv
// spi_sync_edge: SYNC_STAGES-deep synchronizer for one asynchronous pin plus
// single-Clk rise/fall pulses of the synchronized level.
//   Clk, Reset : system clock, synchronous active-high reset
//   d_async    : raw pin
//   rise, fall : one-Clk pulses on synchronized edges
// RST_VAL is the pin's idle level so that leaving reset never fakes an edge.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic d_async,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   lvl;

  assign lvl = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    prev_d = lvl;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;

endmodule

// File: rtl/spi_keycode_slave.sv
// spi_keycode_slave: SPI mode-0 slave exposing a 32 x 8 register file.
//   Clk, Reset      : 50 MHz clock, synchronous active-high reset
//   spi (slave)     : sclk/ss_n/mosi in, miso/miso_oe out (all oversampled in Clk)
//   status_in       : read-only byte returned at address 0 and during the command byte
//   keycode0/1/2/_shoot : registers 1..4
//   wr_strobe/addr/data : one-Clk pulse per committed write
// Command byte: cmd[7:3]=start address, cmd[1]=1 write / 0 read; address
// auto-increments (31 wraps to 0) after each data byte. Address 0 drops writes.
// Optional macro SPI_TIMEOUT_EN: drop back to IDLE when SCLK is idle for
// TIMEOUT_CYCLES Clk while selected; re-select is needed to resume.
module spi_keycode_slave
  import rager_spi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  spi_keycode_slave_if.slave    spi,
  input  logic [7:0]            status_in,
  output logic [7:0]            keycode0,
  output logic [7:0]            keycode1,
  output logic [7:0]            keycode2,
  output logic [7:0]            keycode_shoot,
  output logic                  wr_strobe,
  output logic [4:0]            wr_addr,
  output logic [7:0]            wr_data
);

  // ---------------- pin synchronization ----------------
  logic sclk_rise, sclk_fall, ss_rise, ss_fall;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .Clk(Clk), .Reset(Reset), .d_async(spi.spi_sclk), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .Clk(Clk), .Reset(Reset), .d_async(spi.spi_ss_n), .rise(ss_rise), .fall(ss_fall)
  );

  // mosi only needs the level, delayed identically to sclk so the two stay aligned
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   mosi_s;

  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi.spi_mosi};
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];

  // ---------------- state ----------------
  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;          // bits received in current byte
  logic [7:0]       shift_q, shift_d;      // MOSI shift register
  logic             byte_done_q, byte_done_d;
  logic [4:0]       addr_q, addr_d;
  logic             dir_q, dir_d;          // 1 = write
  logic             load_pend_q, load_pend_d; // reload MISO on next SCLK fall
  logic [7:0]       miso_sr_q, miso_sr_d;
  logic [31:0][7:0] regs_q, regs_d;
  wr_req_t          wr_q, wr_d;
  logic [7:0]       rd_val;
  logic             tmo_hit;

  assign rd_val = (addr_q == ADDR_STATUS) ? status_in : regs_q[addr_q];

`ifdef SPI_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q + TW'(1);
    if (state_q == IDLE || sclk_rise || sclk_fall) tmo_d = '0;
  end

  assign tmo_hit = (tmo_q >= TW'(TIMEOUT_CYCLES));

  always_ff @(posedge Clk) begin
    if (Reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  // no watchdog: the parameter is kept only for a uniform interface
  assign tmo_hit = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // ---------------- next state ----------------
  // A byte is completed on the synchronized 8th SCLK rise (byte_done_q one Clk
  // later) and consumed the Clk after that; SCLK is at most Clk/8, so the next
  // SCLK fall always arrives after the MISO reload has been scheduled.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    byte_done_d = 1'b0;
    addr_d      = addr_q;
    dir_d       = dir_q;
    load_pend_d = load_pend_q;
    miso_sr_d   = miso_sr_q;
    regs_d      = regs_q;
    wr_d        = '{strobe: 1'b0, addr: wr_q.addr, data: wr_q.data};

    if (state_q == IDLE) begin
      if (ss_fall) begin
        state_d     = CMD;
        cnt_d       = '0;
        miso_sr_d   = status_in;
        load_pend_d = 1'b0;
      end
    end else begin
      // a byte that completed before deselect still commits
      if (byte_done_q) begin
        if (state_q == CMD) begin
          addr_d      = shift_q[CMD_ADDR_MSB:CMD_ADDR_LSB];
          dir_d       = shift_q[CMD_DIR_BIT];
          state_d     = DATA;
          load_pend_d = ~shift_q[CMD_DIR_BIT];
        end else begin
          if (dir_q && addr_q != ADDR_STATUS) begin
            regs_d[addr_q] = shift_q;
            wr_d           = '{strobe: 1'b1, addr: addr_q, data: shift_q};
          end
          addr_d      = addr_q + 5'd1;
          load_pend_d = ~dir_q;
        end
      end

      if (ss_rise || tmo_hit) begin
        // deselect wins over a coincident 8th rise; partial byte is dropped
        state_d     = IDLE;
        cnt_d       = '0;
        load_pend_d = 1'b0;
      end else begin
        if (sclk_rise) begin
          shift_d = {shift_q[6:0], mosi_s};
          if (cnt_q == 3'd7) begin
            cnt_d       = '0;
            byte_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        if (sclk_fall) begin
          if (load_pend_q) begin
            miso_sr_d   = rd_val;
            load_pend_d = 1'b0;
          end else begin
            miso_sr_d = {miso_sr_q[6:0], 1'b0};
          end
        end
      end
    end
  end

  // ---------------- registers ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      mosi_sync_q <= '0;
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      addr_q      <= '0;
      dir_q       <= 1'b0;
      load_pend_q <= 1'b0;
      miso_sr_q   <= '0;
      regs_q      <= '0;
      wr_q        <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      byte_done_q <= byte_done_d;
      addr_q      <= addr_d;
      dir_q       <= dir_d;
      load_pend_q <= load_pend_d;
      miso_sr_q   <= miso_sr_d;
      regs_q      <= regs_d;
      wr_q        <= wr_d;
    end
  end

  // ---------------- outputs ----------------
  assign spi.spi_miso_oe = (state_q != IDLE);
  assign spi.spi_miso    = (state_q != IDLE) & miso_sr_q[7];

  assign keycode0      = regs_q[ADDR_KEY0];
  assign keycode1      = regs_q[ADDR_KEY1];
  assign keycode2      = regs_q[ADDR_KEY2];
  assign keycode_shoot = regs_q[ADDR_SHOOT];

  assign wr_strobe = wr_q.strobe;
  assign wr_addr   = wr_q.addr;
  assign wr_data   = wr_q.data;

endmodule
